sha256_core_ctrl: RTL and testbench
===================================

Name: sha256_core_ctrl

Overview:
- Command/sequencing controller for the iterative SHA-256 math core (SHAcore, parameter ITERATIONS).
- Accepts one 512-bit block per command and drives core_feeder and core_count through the ITERATIONS folded passes.
- Holds state and block inputs stable, waits out core latency, then captures the 256-bit digest.
- Chains digests across multi-block messages. Sits between the message padder/host interface and SHAcore.

Parameters:
- ITERATIONS, 1, folding factor of the attached SHAcore; power of two, 1..32; must match the core instance.
- CORE_LATENCY, 1, cycles from the last feed beat until core_hash is valid; 0..15.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  start a new message with this block; chain state = IV.
- next  input  1  continue the message with this block; chain state = previous digest.
- block  input  512  message block, sampled on the accepting edge.
- ready  output  1  high when idle and able to accept init/next.
- digest  output  256  last captured hash, h0 in bits [255:224].
- digest_valid  output  1  one-cycle pulse when digest updates.
- core_feeder  output  1  to SHAcore feeder.
- core_count  output  6  to SHAcore count_value.
- core_state  output  256  to SHAcore state_input, h0 in bits [31:0].
- core_block  output  512  to SHAcore message_block.
- core_hash  input  256  from SHAcore output_hash, h0 in [255:224].

Behaviour:
- Reset (async, immediate):
  - State=IDLE; ready=1; digest=0; digest_valid=0; core_feeder=0; core_count=0; core_block=0.
  - Chain register = IV, so core_state=256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667.
  - Reset mid-operation aborts the block; no digest_valid.
- FSM states: IDLE, FEED, WAIT, CAPTURE.
- IDLE:
  - On an edge with ready=1 and (init|next), the accepting edge E0:
    - core_block<=block.
    - core_state<=IV if init, else chain register.
    - core_count<=0, core_feeder<=0, ready<=0; go to FEED.
  - init and next asserted together: init wins.
  - next with no prior init since reset uses IV, because the chain register resets to IV.
- FEED:
  - Lasts ITERATIONS cycles. core_count steps 0,1,...,ITERATIONS-1, incrementing by 1 each edge, modulo ITERATIONS.
  - core_feeder=0 when core_count==0, else 1. With ITERATIONS=1, core_feeder stays 0 and core_count stays 0.
  - After the count ITERATIONS-1 cycle: go to WAIT if CORE_LATENCY>0, else CAPTURE.
  - On FEED exit: core_count<=0, core_feeder<=0.
- WAIT:
  - CORE_LATENCY cycles, tracked by an internal 4-bit counter.
  - core_state and core_block held unchanged.
- CAPTURE:
  - Sampling edge is E(ITERATIONS+CORE_LATENCY).
  - digest<=core_hash.
  - Chain register <= word-reversed core_hash: chain[32*i+31:32*i] = core_hash[255-32*i:224-32*i] for i=0..7.
  - digest_valid<=1 for exactly one cycle; ready<=1; go to IDLE.
- Timing:
  - digest_valid is high in the cycle after edge E(ITERATIONS+CORE_LATENCY).
  - Throughput is one block per ITERATIONS+CORE_LATENCY+1 cycles.
  - A new command may be accepted on the edge ending the digest_valid cycle (back-to-back).
- Command handling:
  - init/next while ready=0 are ignored; no queuing, no side effects.
  - block changes while busy have no effect on core_block.
- Output stability: digest holds its value until the next CAPTURE; it is not cleared on command acceptance.
- core_state and core_block change only on accepting edges.

Test Plan:
- Reset behaviour: assert reset mid-sequence (ITERATIONS=1) -> outputs immediately take the reset values above, with core_state=IV.
- "abc" test:
  - Stimulus: ITERATIONS=1, CORE_LATENCY=1, real SHAcore; init with block 512'h6162638000…0018.
  - Response: core_state=IV, digest_valid pulse 2 edges after acceptance, digest=256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD.
- Two-block chaining:
  - Stimulus: init with block 6162636462636465…8000000000000000, then next with block 0…01C0.
  - Response: first digest=85E655D6417A17953363376A624CDE5C76E09589CAC5F811CC4B32C1F20E533A; second core_state = word-reversed first digest; second digest=248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1.
- Folding sequence:
  - Stimulus: ITERATIONS=4, CORE_LATENCY=2, stub core; init.
  - Response: core_count=0,1,2,3 with core_feeder=0,1,1,1 on consecutive cycles; digest_valid asserted after edge E6; ready low for 6 cycles.
- Command collisions:
  - init+next together -> IV used (init wins).
  - init pulsed during FEED -> ignored; no extra digest_valid.
  - Stub core returning a constant -> exactly one digest_valid per accepted command.
- Reset mid-operation: reset during WAIT -> no digest_valid; next after reset uses IV; digest=0 until the next capture.

Source files
------------

// File: rtl/sha256_core_ctrl.sv
// sha256_core_ctrl: command and sequencing controller for a folded SHA-256 core.
// Feeds one 512-bit block through ITERATIONS passes and chains digests.
module sha256_core_ctrl #(
  parameter int ITERATIONS   = 1,
  parameter int CORE_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init,
  input  logic         next,
  input  logic [511:0] block,
  output logic         ready,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         core_feeder,
  output logic [5:0]   core_count,
  output logic [255:0] core_state,
  output logic [511:0] core_block,
  input  logic [255:0] core_hash
);

  // SHA-256 initial hash value, h0 in the low word as the core expects.
  localparam logic [255:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [5:0] FEED_LAST = 6'(ITERATIONS - 1);
  localparam logic [3:0] WAIT_LAST = 4'(CORE_LATENCY - 1);
  localparam bit         NO_WAIT   = (CORE_LATENCY == 0);

  // S_CAPTURE is the cycle presenting the freshly captured digest;
  // it is also ready, so a back-to-back command is taken there.
  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic           r_ready;
  logic           r_dv;
  logic [255:0]   r_digest;
  logic [255:0]   r_chain;
  logic [255:0]   r_core_state;
  logic [511:0]   r_core_block;
  logic [5:0]     r_count;
  logic           r_feeder;
  logic [3:0]     r_wait;

  logic           w_accept;
  logic           w_feed_last;
  logic           w_wait_last;
  logic           w_capture;

  // The core outputs h0 high; the core expects h0 low on state_input.
  function automatic logic [255:0] f_word_rev(input logic [255:0] h);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[32*i +: 32] = h[224-32*i +: 32];
    end
    return r;
  endfunction

  assign w_accept    = r_ready & (init | next);
  assign w_feed_last = (r_state == S_FEED) && (r_count == FEED_LAST);
  assign w_wait_last = (r_state == S_WAIT) && (r_wait == WAIT_LAST);
  assign w_capture   = (w_feed_last && NO_WAIT) || w_wait_last;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_CAPTURE: begin
        w_state_nxt = w_accept ? S_FEED : S_IDLE;
      end
      S_FEED: begin
        if (w_feed_last) begin
          w_state_nxt = NO_WAIT ? S_CAPTURE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_wait_last) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command capture and core input registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_core_block <= '0;
      r_core_state <= IV;
    end else if (w_accept) begin
      r_core_block <= block;
      r_core_state <= init ? IV : r_chain;
    end
  end

  // Fold counter and feeder strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_feeder <= 1'b0;
    end else if (w_accept || w_feed_last) begin
      r_count  <= '0;
      r_feeder <= 1'b0;
    end else if (r_state == S_FEED) begin
      r_count  <= r_count + 6'd1;
      r_feeder <= 1'b1;
    end
  end

  // Core latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait <= r_wait + 4'd1;
    end else begin
      r_wait <= '0;
    end
  end

  // Ready flag: dropped on accept, raised on capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b1;
    end else if (w_accept) begin
      r_ready <= 1'b0;
    end else if (w_capture) begin
      r_ready <= 1'b1;
    end
  end

  // Digest capture, chaining and valid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digest <= '0;
      r_chain  <= IV;
      r_dv     <= 1'b0;
    end else begin
      r_dv <= w_capture;
      if (w_capture) begin
        r_digest <= core_hash;
        r_chain  <= f_word_rev(core_hash);
      end
    end
  end

  assign ready        = r_ready;
  assign digest       = r_digest;
  assign digest_valid = r_dv;
  assign core_feeder  = r_feeder;
  assign core_count   = r_count;
  assign core_state   = r_core_state;
  assign core_block   = r_core_block;

endmodule

// File: tb/tb_sha256_core_ctrl.sv
// tb_sha256_core_ctrl: randomized bench with a behavioural SHA-256 core stub
// and a message-level chaining model.
module tb_sha256_core_ctrl;

  localparam int ITER = 4;
  localparam int LAT  = 2;

  localparam logic [255:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk;
  logic         reset;
  logic         init;
  logic         next;
  logic [511:0] block;
  logic         ready;
  logic [255:0] digest;
  logic         digest_valid;
  logic         core_feeder;
  logic [5:0]   core_count;
  logic [255:0] core_state;
  logic [511:0] core_block;
  logic [255:0] core_hash;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_hash = -100;

  logic [255:0] exp_chain;
  logic [255:0] last_digest;

  sha256_core_ctrl #(
    .ITERATIONS   (ITER),
    .CORE_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .next         (next),
    .block        (block),
    .ready        (ready),
    .digest       (digest),
    .digest_valid (digest_valid),
    .core_feeder  (core_feeder),
    .core_count   (core_count),
    .core_state   (core_state),
    .core_block   (core_block),
    .core_hash    (core_hash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One SHA-256 compression; state has h0 low, result has h0 high.
  function automatic logic [255:0] sha_comp(input logic [255:0] st,
                                            input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 8; i++) hv[i] = st[32*i +: 32];
    for (int t = 0; t < 16; t++) w[t] = blk[480-32*t +: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
    e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
    for (int t = 0; t < 64; t++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[t] + w[t];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
            hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
  endfunction

  function automatic logic [255:0] rev8(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[255-32*i -: 32];
    return r;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Core stub: correct hash only in the cycle before the capture edge.
  always @* begin
    if (cyc == t_hash) core_hash = sha_comp(core_state, core_block);
    else core_hash = {8{32'hdeadbeef ^ 32'(cyc)}};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic run_cmd(input bit do_init, input bit do_next,
                         input logic [511:0] blk, input bit noise,
                         output logic [255:0] dg);
    logic [255:0] exp_st;
    logic [255:0] exp_d;
    logic [5:0]   exp_cnt;
    logic         exp_fd;
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_wait: got %b exp 1", ready);
    end
    exp_st = do_init ? IV : exp_chain;
    exp_d  = sha_comp(exp_st, blk);
    init   = do_init;
    next   = do_next;
    block  = blk;
    t_hash = cyc + ITER + LAT;
    for (int k = 0; k < ITER + LAT; k++) begin
      @(negedge clk);
      if (noise) begin
        init  = 1'($urandom);
        next  = 1'($urandom);
        block = rand_blk();
      end else begin
        init = 1'b0;
        next = 1'b0;
      end
      exp_cnt = (k < ITER) ? 6'(k) : 6'd0;
      exp_fd  = (k < ITER) && (k != 0);
      total++;
      if ({ready, digest_valid, core_feeder, core_count} !==
          {2'b00, exp_fd, exp_cnt}) begin
        bad++;
        $display("FAIL busy_ctl k=%0d: got rdy=%b dv=%b fd=%b cnt=%0d exp 0 0 %b %0d",
                 k, ready, digest_valid, core_feeder, core_count,
                 exp_fd, exp_cnt);
      end
      total++;
      if (core_state !== exp_st || core_block !== blk) begin
        bad++;
        $display("FAIL busy_data k=%0d: got state=%h exp %h", k,
                 core_state, exp_st);
      end
      total++;
      if (digest !== last_digest) begin
        bad++;
        $display("FAIL digest_hold k=%0d: got %h exp %h", k, digest,
                 last_digest);
      end
    end
    @(negedge clk);
    init = 1'b0;
    next = 1'b0;
    total++;
    if ({digest_valid, ready, core_feeder, core_count} !== 9'b110000000) begin
      bad++;
      $display("FAIL done_ctl: got dv=%b rdy=%b fd=%b cnt=%0d exp 1 1 0 0",
               digest_valid, ready, core_feeder, core_count);
    end
    total++;
    if (digest !== exp_d) begin
      bad++;
      $display("FAIL digest: got %h exp %h", digest, exp_d);
    end
    exp_chain   = rev8(exp_d);
    last_digest = exp_d;
    dg          = digest;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      total++;
      if (digest_valid !== 1'b0 || ready !== 1'b1 ||
          digest !== last_digest) begin
        bad++;
        $display("FAIL idle: got dv=%b rdy=%b dig=%h exp 0 1 %h",
                 digest_valid, ready, digest, last_digest);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    total++;
    if ({ready, digest_valid, core_feeder, core_count} !== 9'b100000000) begin
      bad++;
      $display("FAIL %s_ctl: got rdy=%b dv=%b fd=%b cnt=%0d exp 1 0 0 0",
               tag, ready, digest_valid, core_feeder, core_count);
    end
    total++;
    if (digest !== 256'h0 || core_block !== 512'h0 || core_state !== IV) begin
      bad++;
      $display("FAIL %s_data: got dig=%h st=%h exp 0 %h", tag, digest,
               core_state, IV);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    init  = 1'b0;
    next  = 1'b0;
    block = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset_init");
    reset = 1'b0;
    exp_chain   = IV;
    last_digest = '0;
    init  = 1'b1;
    block = rand_blk();
    repeat (3) @(negedge clk);
    init = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_vals("reset_async");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_abc();
    logic [255:0] d;
    run_cmd(1'b1, 1'b0, {32'h61626380, 416'h0, 64'h18}, 1'b0, d);
    total++;
    if (d !== 256'hBA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD) begin
      bad++;
      $display("FAIL abc: got %h", d);
    end
    idle(2);
  endtask

  task automatic test_two_block();
    logic [255:0] d;
    logic [511:0] b1;
    b1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    run_cmd(1'b1, 1'b0, b1, 1'b0, d);
    total++;
    if (d !== 256'h85E655D6417A17953363376A624CDE5C76E09589CAC5F811CC4B32C1F20E533A) begin
      bad++;
      $display("FAIL two_block_1: got %h", d);
    end
    idle(1);
    run_cmd(1'b0, 1'b1, 512'h1c0, 1'b0, d);
    total++;
    if (d !== 256'h248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1) begin
      bad++;
      $display("FAIL two_block_2: got %h", d);
    end
    idle(2);
  endtask

  task automatic test_collision();
    logic [255:0] d;
    run_cmd(1'b0, 1'b1, rand_blk(), 1'b1, d);
    idle(1);
    run_cmd(1'b1, 1'b1, rand_blk(), 1'b1, d);
    idle(3);
  endtask

  task automatic test_reset_mid();
    logic [255:0] d;
    run_cmd(1'b1, 1'b0, rand_blk(), 1'b0, d);
    init  = 1'b1;
    block = rand_blk();
    @(negedge clk);
    init = 1'b0;
    repeat (ITER) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("reset_wait");
    exp_chain   = IV;
    last_digest = '0;
    @(negedge clk);
    reset = 1'b0;
    idle(ITER + LAT + 2);
    run_cmd(1'b0, 1'b1, rand_blk(), 1'b0, d);
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    for (int i = 0; i < 4; i++) begin
      run_cmd(i == 0, i != 0, rand_blk(), 1'b0, d);
    end
    idle(2);
  endtask

  task automatic test_random();
    logic [255:0] d;
    bit bi, bn;
    for (int i = 0; i < 10; i++) begin
      bi = 1'($urandom);
      bn = bi ? 1'($urandom) : 1'b1;
      run_cmd(bi, bn, rand_blk(), 1'($urandom), d);
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_two_block();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
